// File: rtl/forwarding_hazard_unit.sv
// EXE-stage forwarding producer: tracks EX/MEM destinations, issues registered one-hot
// MEM/WB forward selects for the instruction entering EXE, and stalls one cycle on load-use.
module forwarding_hazard_unit #(
   parameter int CNT_W = 16
) (
   input  logic             clk,
   input  logic             rst_n,
   input  logic             id_valid,
   input  logic [4:0]       id_rs,
   input  logic [4:0]       id_rt,
   input  logic [4:0]       id_rd,
   input  logic             id_uses_rt,
   input  logic             id_regdst,
   input  logic             id_reg_write,
   input  logic             id_mem_read,
   input  logic             flush,
   output logic             memAdelant_rs,
   output logic             memAdelant_rt,
   output logic             wbAdelant_rs,
   output logic             wbAdelant_rt,
   output logic             stall,
   output logic [CNT_W-1:0] stall_count
);

   localparam logic [CNT_W-1:0] LP_CNT_MAX = {CNT_W{1'b1}};

   // The WB slot is only needed for the selects already latched into wbAdelant_*, and MEM
   // never needs its load flag, so neither is stored.
   logic [4:0]       r_ex_dst;
   logic             r_ex_wr;
   logic             r_ex_ld;
   logic [4:0]       r_mem_dst;
   logic             r_mem_wr;
   logic             r_mem_rs;
   logic             r_mem_rt;
   logic             r_wb_rs;
   logic             r_wb_rt;
   logic [CNT_W-1:0] r_stall_count;

   logic [4:0] w_id_dst;
   logic       w_ex_prod;
   logic       w_mem_prod;
   logic       w_ex_hit_rs;
   logic       w_ex_hit_rt;
   logic       w_mem_hit_rs;
   logic       w_mem_hit_rt;
   logic       w_stall;
   logic       w_advance;

   always_comb begin
      w_id_dst     = id_regdst ? id_rd : id_rt;
      w_ex_prod    = r_ex_wr  & (r_ex_dst  != 5'd0);
      w_mem_prod   = r_mem_wr & (r_mem_dst != 5'd0);
      w_ex_hit_rs  = w_ex_prod  & (r_ex_dst  == id_rs);
      w_ex_hit_rt  = w_ex_prod  & (r_ex_dst  == id_rt) & id_uses_rt;
      w_mem_hit_rs = w_mem_prod & (r_mem_dst == id_rs);
      w_mem_hit_rt = w_mem_prod & (r_mem_dst == id_rt) & id_uses_rt;
      // Flush outranks the hazard: a squashed consumer never stalls.
      w_stall      = id_valid & ~flush & r_ex_ld & (w_ex_hit_rs | w_ex_hit_rt);
      w_advance    = id_valid & ~flush & ~w_stall;
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         r_ex_dst  <= 5'd0;
         r_ex_wr   <= 1'b0;
         r_ex_ld   <= 1'b0;
         r_mem_dst <= 5'd0;
         r_mem_wr  <= 1'b0;
      end else begin
         r_mem_dst <= r_ex_dst;
         r_mem_wr  <= r_ex_wr;
         if (w_advance) begin
            r_ex_dst <= w_id_dst;
            r_ex_wr  <= id_reg_write;
            r_ex_ld  <= id_mem_read;
         end else begin
            r_ex_dst <= 5'd0;
            r_ex_wr  <= 1'b0;
            r_ex_ld  <= 1'b0;
         end
      end
   end

   // Current EX becomes MEM and current MEM becomes WB, so EX hits select MEM (priority).
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         r_mem_rs <= 1'b0;
         r_mem_rt <= 1'b0;
         r_wb_rs  <= 1'b0;
         r_wb_rt  <= 1'b0;
      end else begin
         r_mem_rs <= w_advance & w_ex_hit_rs;
         r_mem_rt <= w_advance & w_ex_hit_rt;
         r_wb_rs  <= w_advance & w_mem_hit_rs & ~w_ex_hit_rs;
         r_wb_rt  <= w_advance & w_mem_hit_rt & ~w_ex_hit_rt;
      end
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         r_stall_count <= '0;
      end else if (w_stall && (r_stall_count != LP_CNT_MAX)) begin
         r_stall_count <= r_stall_count + CNT_W'(1);
      end
   end

   assign memAdelant_rs = r_mem_rs;
   assign memAdelant_rt = r_mem_rt;
   assign wbAdelant_rs  = r_wb_rs;
   assign wbAdelant_rt  = r_wb_rt;
   assign stall         = w_stall;
   assign stall_count   = r_stall_count;

endmodule

// File: doc/forwarding_hazard_unit.md
# forwarding_hazard_unit

Producer side of the EXE-stage forwarding interface. Tracks the destination register and write/load flags of the instructions in the EX, MEM and WB slots of the MIPS pipeline. On every ID→EX advance it issues registered one-hot forwarding selects (`memAdelant_rs/rt`, `wbAdelant_rs/rt`) for the instruction entering EXE. It also detects load-use hazards and stalls ID/IF for one cycle while inserting a bubble into EX.

## Interface
Parameters:
- `CNT_W`, 16: width of the saturating stall counter.

Ports:
- `clk` in 1: single clock; all state updates on rising edge.
- `rst_n` in 1: reset, asynchronous, active-low.
- `id_valid` in 1: ID slot holds a real instruction.
- `id_rs` in 5: rs of the instruction in ID.
- `id_rt` in 5: rt of the instruction in ID.
- `id_rd` in 5: rd of the instruction in ID.
- `id_uses_rt` in 1: instruction reads rt as an ALU/store operand (0 for immediates and loads).
- `id_regdst` in 1: destination is rd when 1, rt when 0.
- `id_reg_write` in 1: instruction writes the register file.
- `id_mem_read` in 1: instruction is a load.
- `flush` in 1: branch taken; squash the ID instruction.
- `memAdelant_rs` out 1: EX rs operand takes the MEM-stage value.
- `memAdelant_rt` out 1: EX rt operand takes the MEM-stage value.
- `wbAdelant_rs` out 1: EX rs operand takes the WB-stage value.
- `wbAdelant_rt` out 1: EX rt operand takes the WB-stage value.
- `stall` out 1: combinational; hold PC and IF/ID this cycle.
- `stall_count` out CNT_W: number of stall cycles, saturating.

## Operation
- Three internal slots: EX, MEM, WB. Each holds `dst[4:0]`, `wr` and `ld`.
- ID destination: `id_dst = id_regdst ? id_rd : id_rt`.
- A slot is a producer only when `wr=1` and `dst != 0`. Register 0 is never forwarded and never causes a stall.
- Hazard, combinational: `stall = id_valid & !flush & EX.ld & EX.wr & EX.dst != 0`, and EX.dst equals `id_rs`, or equals `id_rt` with `id_uses_rt=1`.
- Next EX slot:
  - Normal advance (no stall, no flush, `id_valid=1`): EX ← {id_dst, id_reg_write, id_mem_read}.
  - Bubble (stall, or flush, or `id_valid=0`): EX ← {0, 0, 0}.
- MEM ← EX and WB ← MEM every cycle, unconditionally.
- Forward selects are registered. They are computed from the ID operands against the current EX and MEM slots, which become MEM and WB next cycle:
  - `memAdelant_rs` ← producer(EX) & EX.dst == id_rs.
  - `wbAdelant_rs` ← producer(MEM) & MEM.dst == id_rs & !(producer(EX) & EX.dst == id_rs).
  - The rt pair uses the same rules, gated by `id_uses_rt`.
  - The MEM match has priority, so each operand pair is never both 1.
  - On a bubble all four selects are loaded with 0.
- A producer three slots ahead is covered by the write-first register file; this block does not forward it.
- `stall_count` increments on each rising edge where `stall=1` and saturates at all-ones.
- Flush has priority over stall: a flush cycle never asserts `stall` and never counts.

## Timing
- Reset (`rst_n=0`, asynchronous): all slots {0,0,0}, all four selects 0, `stall_count=0`. `stall` is 0 because EX.ld=0.
- Forward-select latency: selects are valid for the entire cycle in which the consumer occupies EXE, i.e. one edge after it was presented in ID.
- Load-use case: `stall` lasts exactly one cycle per load-use pair. The re-presented ID instruction then sees the load in MEM and receives `wbAdelant_*`.
- Reset deasserted mid-stall: the pipeline restarts empty and the stall drops immediately.
- Back-to-back loads feeding a consumer: the stall condition is evaluated only against the EX slot, so there is at most one stall per consumer.

## Test plan
- Reset, then ADD $3 followed by SUB $4,$3,$5 (rs=3) → on the SUB's EX cycle `memAdelant_rs=1` and the other three selects 0. `stall` never asserts.
- ADD $3, then NOP, then OR rt=3 (`id_uses_rt=1`) → `wbAdelant_rt=1` in the OR's EX cycle.
- ADD $3, ADD $3, then AND rs=3 → `memAdelant_rs=1`, `wbAdelant_rs=0` (MEM priority).
- LW $2, then ADD rs=2 → `stall=1` for one cycle and `stall_count` becomes 1. In the next EX cycle the selects are 0 (bubble). In the following cycle `wbAdelant_rs=1` for the ADD.
- LW $0, then ADD rs=0 → no stall and all selects 0. Separately, LW $2 with `flush=1` on the consumer cycle → `stall=0`, `stall_count` unchanged, EX slot bubbled.
- Preload `stall_count` to saturation with repeated load-use pairs (CNT_W=2 build) → the count holds at 3. Assert `rst_n=0` mid-stall → `stall` and all selects drop to 0 asynchronously and the count clears to 0.
